// File: rtl/hazard_sched_unit.sv
// Hazard scheduler for the 5-stage RV32 pipeline: stall/flush sequencing for load-use,
// branch squash and data-memory waits, plus execute-stage operand forwarding.
module hazard_sched_unit #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RS1_D,
   input  logic [4:0]       RS2_D,
   input  logic [4:0]       RS1_E,
   input  logic [4:0]       RS2_E,
   input  logic [4:0]       RD_E,
   input  logic             ResultSrcE,
   input  logic             PCSrcE,
   input  logic [4:0]       RD_M,
   input  logic             RegWriteM,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic [4:0]       RD_W,
   input  logic             RegWriteW,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERR      = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WC_W-1:0]   wait_q, wait_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              lw_haz;
   logic              mem_busy;

   assign lw_haz   = ResultSrcE && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
   assign mem_busy = MemReqM && !MemReadyM;

   // Operand forwarding: memory stage has priority over writeback
   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      if (!rst) begin
         if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS1_E))      ForwardAE = 2'b10;
         else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS1_E)) ForwardAE = 2'b01;
         if (RegWriteM && (RD_M != 5'd0) && (RD_M == RS2_E))      ForwardBE = 2'b10;
         else if (RegWriteW && (RD_W != 5'd0) && (RD_W == RS2_E)) ForwardBE = 2'b01;
      end
   end

   // Next-state and stall/flush decode
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      err_d   = err_q;
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      StallM  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (mem_busy) begin
               // Branch in E is held, so it resolves once memory releases the pipe
               StallF  = 1'b1;
               StallD  = 1'b1;
               StallE  = 1'b1;
               StallM  = 1'b1;
               state_d = ST_MEM_WAIT;
               wait_d  = WC_W'(1);
            end else if (PCSrcE) begin
               FlushD = 1'b1;
               FlushE = 1'b1;
            end else if (lw_haz) begin
               StallF = 1'b1;
               StallD = 1'b1;
               FlushE = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            if (MemReadyM) begin
               state_d = ST_RUN;
               wait_d  = '0;
            end else if (wait_q == WC_W'(MEM_TIMEOUT)) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + WC_W'(1);
            end
         end
         ST_ERR: begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
      if (rst) begin
         StallF = 1'b0;
         StallD = 1'b0;
         StallE = 1'b0;
         StallM = 1'b0;
         FlushD = 1'b0;
         FlushE = 1'b0;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (StallF && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mem_err   = err_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Self-checking bench for hazard_sched_unit: directed hazard scenarios followed by random
// traffic, all compared against a behavioural pipeline-control model.
module tb_hazard_sched_unit;

   localparam int unsigned TO   = 4;
   localparam int unsigned CW   = 4;
   localparam int          CMAX = (1 << CW) - 1;
   localparam int          M_RUN = 0, M_WAIT = 1, M_ERR = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
   logic          ResultSrcE, PCSrcE, RegWriteM, MemReqM, MemReadyM, RegWriteW;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, mem_err;
   logic [1:0]    ForwardAE, ForwardBE;
   logic [CW-1:0] stall_cnt;

   always #5 clk = ~clk;

   hazard_sched_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E), .RD_E(RD_E),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RD_M(RD_M), .RegWriteM(RegWriteM),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .RD_W(RD_W), .RegWriteW(RegWriteW),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int         m_mode, m_wait, m_err, m_cnt;
   logic [3:0] e_stall;
   logic [1:0] e_flush, e_fa, e_fb;
   logic       e_busy;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
      if (RegWriteM && RD_M != 5'd0 && RD_M == rs) return 2'b10;
      if (RegWriteW && RD_W != 5'd0 && RD_W == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_mode = M_RUN; m_wait = 0; m_err = 0; m_cnt = 0;
   endtask

   task automatic model_outputs();
      logic lw;
      lw      = ResultSrcE && RD_E != 5'd0 && (RD_E == RS1_D || RD_E == RS2_D);
      e_busy  = MemReqM && !MemReadyM;
      e_stall = 4'b0000;
      e_flush = 2'b00;
      e_fa    = rst ? 2'b00 : fwd_ref(RS1_E);
      e_fb    = rst ? 2'b00 : fwd_ref(RS2_E);
      if (!rst) begin
         if (m_mode != M_RUN || e_busy) e_stall = 4'b1111;
         else if (PCSrcE)               e_flush = 2'b11;
         else if (lw) begin
            e_stall = 4'b1100;
            e_flush = 2'b01;
         end
      end
   endtask

   task automatic model_clock();
      if (e_stall[3] && m_cnt < CMAX) m_cnt++;
      case (m_mode)
         M_RUN:  if (e_busy) begin m_mode = M_WAIT; m_wait = 1; end
         M_WAIT: begin
            if (MemReadyM)        begin m_mode = M_RUN; m_wait = 0; end
            else if (m_wait == TO) begin m_mode = M_ERR; m_err = 1; end
            else                   m_wait++;
         end
         default: ;
      endcase
   endtask

   // Called just after a falling edge with inputs applied; checks, then advances one clock.
   task automatic cycle();
      #1;
      if (rst) model_reset();
      model_outputs();
      chk("stalls",    32'({StallF, StallD, StallE, StallM}), 32'(e_stall));
      chk("flushes",   32'({FlushD, FlushE}), 32'(e_flush));
      chk("ForwardAE", 32'(ForwardAE), 32'(e_fa));
      chk("ForwardBE", 32'(ForwardBE), 32'(e_fb));
      chk("mem_err",   32'(mem_err), 32'(m_err));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      @(posedge clk);
      if (!rst) model_clock();
      @(negedge clk);
   endtask

   task automatic idle();
      RS1_D = 5'd0; RS2_D = 5'd0; RS1_E = 5'd0; RS2_E = 5'd0; RD_E = 5'd0;
      RD_M = 5'd0; RD_W = 5'd0; ResultSrcE = 1'b0; PCSrcE = 1'b0; RegWriteM = 1'b0;
      MemReqM = 1'b0; MemReadyM = 1'b0; RegWriteW = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      model_reset();
      @(negedge clk);
      cycle();
      rst = 1'b0;
      cycle();

      // forwarding priority
      RegWriteM = 1'b1; RD_M = 5'd5; RS1_E = 5'd5; RegWriteW = 1'b1; RD_W = 5'd5;
      #1 chk("fwd_m_prio", 32'(ForwardAE), 32'd2);
      cycle();
      RD_M = 5'd0;
      #1 chk("fwd_w", 32'(ForwardAE), 32'd1);
      cycle();
      RegWriteW = 1'b0;
      #1 chk("fwd_none", 32'(ForwardAE), 32'd0);
      cycle();
      idle();

      // load-use bubble
      do_reset();
      ResultSrcE = 1'b1; RD_E = 5'd7; RS2_D = 5'd7;
      #1 chk("lu_stall", 32'({StallF, StallD, FlushE}), 32'b111);
      cycle();
      idle();
      #1 chk("lu_cnt", 32'(stall_cnt), 32'd1);
      ResultSrcE = 1'b1; RD_E = 5'd0; RS2_D = 5'd0;
      #1 chk("lu_x0", 32'(StallF), 32'd0);
      cycle();

      // branch wins over load-use
      ResultSrcE = 1'b1; RD_E = 5'd9; RS1_D = 5'd9; PCSrcE = 1'b1;
      #1 chk("br_flush", 32'({FlushD, FlushE, StallF}), 32'b110);
      cycle();
      idle();
      #1 chk("br_cnt", 32'(stall_cnt), 32'd1);

      // memory wait released after three busy cycles
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      repeat (3) cycle();
      MemReadyM = 1'b1;
      #1 chk("mw_last_stall", 32'(StallM), 32'd1);
      cycle();
      idle();
      #1 chk("mw_cnt", 32'(stall_cnt), 32'd4);
      chk("mw_run", 32'(StallF), 32'd0);
      cycle();

      // timeout into ERR, sticky until async reset
      do_reset();
      MemReqM = 1'b1; MemReadyM = 1'b0;
      repeat (5) cycle();
      #1 chk("to_err", 32'(mem_err), 32'd1);
      MemReadyM = 1'b1;
      repeat (3) cycle();
      #1 chk("to_hold", 32'({StallF, mem_err}), 32'b11);
      rst = 1'b1;
      #1 chk("to_async_rst", 32'({StallF, StallD, StallE, StallM, mem_err}), 32'd0);
      cycle();
      rst = 1'b0;
      idle();
      cycle();

      // stall counter saturation
      ResultSrcE = 1'b1; RD_E = 5'd7; RS1_D = 5'd7;
      repeat (20) cycle();
      idle();
      #1 chk("sat_cnt", 32'(stall_cnt), 32'(CMAX));
      cycle();

      // random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rst        = ($urandom_range(0, 99) < 3) || (m_mode == M_ERR && $urandom_range(0, 3) == 0);
         RS1_D      = 5'($urandom_range(0, 3));
         RS2_D      = 5'($urandom_range(0, 3));
         RS1_E      = 5'($urandom_range(0, 3));
         RS2_E      = 5'($urandom_range(0, 3));
         RD_E       = 5'($urandom_range(0, 3));
         RD_M       = 5'($urandom_range(0, 3));
         RD_W       = 5'($urandom_range(0, 3));
         ResultSrcE = ($urandom_range(0, 9) < 4);
         PCSrcE     = ($urandom_range(0, 3) == 0);
         RegWriteM  = ($urandom_range(0, 9) < 6);
         RegWriteW  = ($urandom_range(0, 9) < 6);
         MemReqM    = ($urandom_range(0, 3) == 0);
         MemReadyM  = ($urandom_range(0, 1) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
